tcdm_block_reader: RTL and testbench

TCDM_BLOCK_READER -- requirements
Module: tcdm_block_reader

---
 rtl/tcdm_reader_pkg.sv | 19 +
 rtl/tcdm_reader_fifo.sv | 50 +++++
 rtl/tcdm_block_reader.sv | 155 +++++++++++++++
 tb/tb_tcdm_block_reader.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcdm_reader_pkg.sv
// Shared types and TCDM protocol constants for the TCDM block reader.
package tcdm_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]  BE_ALL     = 4'hF;
  localparam logic        WEN_READ   = 1'b1;
  localparam int unsigned WORD_BYTES = 4;
  localparam logic [31:0] ADDR_STEP  = 32'(WORD_BYTES);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/tcdm_reader_fifo.sv
// Synchronous response FIFO: no bypass, push and pop may share a cycle even when full.
module tcdm_reader_fifo #(
  parameter int unsigned  DEPTH = 4,
  parameter int unsigned  WIDTH = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      usage_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign usage_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (usage_o == '0);
  assign full_o  = (usage_o == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tcdm_block_reader.sv
// Reads a block of words over a TCDM master port and streams them out in order.
// Optional running checksum enabled by defining TCDM_READER_CHECKSUM_EN.
import tcdm_reader_pkg::*;

module tcdm_block_reader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [CNT_WIDTH-1:0] num_words_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 tcdm_req_o,
  output logic [31:0]          tcdm_add_o,
  output logic                 tcdm_wen_o,
  output logic [31:0]          tcdm_wdata_o,
  output logic [3:0]           tcdm_be_o,
  input  logic                 tcdm_gnt_i,
  input  logic [31:0]          tcdm_r_rdata_i,
  input  logic                 tcdm_r_valid_i,
  output logic [31:0]          data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [31:0]          checksum_o,
  output state_e               dbg_state_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [CNT_WIDTH-1:0] issue_left_q, issue_left_d;
  logic [CNT_WIDTH-1:0] pop_left_q, pop_left_d;
  logic [AW:0]          outst_q, outst_d;
  logic                 done_q, done_d;

  logic        gnt_fire, rsp_take, pop_fire, has_room;
  logic        fifo_full, fifo_empty;
  logic [AW:0] fifo_usage;
  logic [AW+1:0] inflight;

  // Handshakes: a request is granted on tcdm_req_o & tcdm_gnt_i; a stream word
  // moves on valid_o & ready_i; r_valid is a single-cycle pulse with no backpressure.
  assign inflight   = {1'b0, outst_q} + {1'b0, fifo_usage};
  assign has_room   = !fifo_full && (inflight < (AW+2)'(FIFO_DEPTH));
  assign tcdm_req_o = (state_q == ST_ISSUE) && has_room;
  assign gnt_fire   = tcdm_req_o && tcdm_gnt_i;
  assign rsp_take   = tcdm_r_valid_i && (outst_q != '0);
  assign valid_o    = !fifo_empty;
  assign pop_fire   = valid_o && ready_i;

  assign tcdm_add_o   = addr_q;
  assign tcdm_wen_o   = WEN_READ;
  assign tcdm_be_o    = BE_ALL;
  assign tcdm_wdata_o = '0;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign dbg_state_o  = state_q;

  tcdm_reader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_take),
    .wdata_i (tcdm_r_rdata_i),
    .pop_i   (pop_fire),
    .rdata_o (data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop_left_q;
    done_d       = 1'b0;
    // Grant and response in the same cycle cancel out.
    outst_d      = outst_q + (AW+1)'(gnt_fire) - (AW+1)'(rsp_take);

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d       = word_align(base_addr_i);
          issue_left_d = num_words_i;
          pop_left_d   = num_words_i;
          if (num_words_i == '0) done_d = 1'b1;
          else                   state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (gnt_fire) begin
          addr_d       = addr_q + ADDR_STEP;
          issue_left_d = issue_left_q - CNT_WIDTH'(1);
          if (issue_left_q == CNT_WIDTH'(1)) state_d = ST_DRAIN;
        end
        if (pop_fire) pop_left_d = pop_left_q - CNT_WIDTH'(1);
      end
      ST_DRAIN: begin
        if (pop_fire) begin
          pop_left_d = pop_left_q - CNT_WIDTH'(1);
          if (pop_left_q == CNT_WIDTH'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      outst_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      outst_q      <= outst_d;
      done_q       <= done_d;
    end
  end

`ifdef TCDM_READER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if ((state_q == ST_IDLE) && start_i) csum_d = '0;
    else if (pop_fire)                   csum_d = csum_q + data_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign checksum_o = csum_q;
`else
  assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_tcdm_block_reader.sv
// Self-checking bench for tcdm_block_reader: randomized TCDM slave and stream sink
// against a queue-based transaction model, plus directed literal scenarios.
module tb_tcdm_block_reader;
  import tcdm_reader_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          rst_i, start_i, busy_o, done_o;
  logic [31:0]   base_addr_i;
  logic [CW-1:0] num_words_i;
  logic          tcdm_req_o, tcdm_wen_o, tcdm_gnt_i, tcdm_r_valid_i;
  logic [31:0]   tcdm_add_o, tcdm_wdata_o, tcdm_r_rdata_i;
  logic [3:0]    tcdm_be_o;
  logic [31:0]   data_o, checksum_o;
  logic          valid_o, ready_i;
  state_e        dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  tcdm_block_reader #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i),
    .num_words_i(num_words_i), .busy_o(busy_o), .done_o(done_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_wdata_o(tcdm_wdata_o), .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_rdata_i(tcdm_r_rdata_i), .tcdm_r_valid_i(tcdm_r_valid_i),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .checksum_o(checksum_o), .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];       // words granted but not yet popped, in order
  logic [31:0] rsp_data_q[$];  // responses the slave still has to return
  int          rsp_due_q[$];
  logic [31:0] force_q[$];     // overrides for response data
  logic [31:0] grant_log[$];

  int          cyc = 0;
  int          m_outst = 0, m_fifo = 0, m_left_issue = 0, m_left_pop = 0;
  bit          m_active = 0, m_done_next = 0;
  logic [31:0] m_addr = '0, m_sum = '0;
  int          gnt_pct = 100, rdy_pct = 100, lat_max = 1;
  bit          start_pend = 0, rst_pend = 0;
  logic [31:0] start_base = '0;
  int          start_num = 0;
  int          done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: compare at negedge, then choose inputs for the next posedge and
  // advance the model by what that posedge will do.
  task automatic step();
    bit          req_exp, act_now, rv;
    logic [31:0] d;
    int          due;
    @(negedge clk);
    cyc++;
    req_exp = m_active && (m_left_issue > 0) && (m_outst + m_fifo < DEPTH);
    act_now = m_active;

    check("busy", {31'b0, busy_o}, {31'b0, m_active});
    check("done", {31'b0, done_o}, {31'b0, m_done_next});
    check("req", {31'b0, tcdm_req_o}, {31'b0, req_exp});
    check("valid", {31'b0, valid_o}, {31'b0, (m_fifo != 0)});
    check("static", {23'b0, tcdm_wen_o, tcdm_be_o, 4'b0}, {23'b0, 1'b1, 4'hF, 4'b0});
    check("wdata", tcdm_wdata_o, 32'h0);
    if (req_exp) check("addr", tcdm_add_o, m_addr);
    if (m_fifo != 0 && exp_q.size() > 0) check("data", data_o, exp_q[0]);
`ifdef TCDM_READER_CHECKSUM_EN
    check("checksum", checksum_o, m_sum);
`else
    check("checksum", checksum_o, 32'h0);
`endif
    if (done_o) done_cnt++;
    m_done_next = 0;

    // response channel (in order, one per cycle)
    rv = 0;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_rdata_i = $urandom;
    if (rsp_due_q.size() > 0 && rsp_due_q[0] == cyc) begin
      tcdm_r_valid_i = 1'b1;
      tcdm_r_rdata_i = rsp_data_q.pop_front();
      void'(rsp_due_q.pop_front());
      rv = 1;
    end else if (rsp_due_q.size() == 0 && $urandom_range(99) < 5) begin
      tcdm_r_valid_i = 1'b1;   // stray response, nothing outstanding
      rv = 1;
    end

    start_i     = 1'b0;
    base_addr_i = $urandom;
    num_words_i = CW'($urandom);
    rst_i       = rst_pend;
    if (rst_pend) begin
      rst_pend = 0;
      tcdm_gnt_i = 1'b0;
      ready_i = 1'b0;
      m_active = 0; m_outst = 0; m_fifo = 0; m_left_issue = 0; m_left_pop = 0;
      m_sum = '0; m_addr = '0;
      exp_q.delete();
      return;
    end

    tcdm_gnt_i = ($urandom_range(99) < gnt_pct);
    ready_i    = ($urandom_range(99) < rdy_pct);

    if (m_fifo > 0 && ready_i) begin
      d = exp_q.pop_front();
      m_sum = m_sum + d;
      m_fifo--;
      m_left_pop--;
      if (m_left_pop == 0) begin
        m_active = 0;
        m_done_next = 1;
      end
    end
    if (rv && m_outst > 0) begin
      m_outst--;
      m_fifo++;
    end
    if (req_exp && tcdm_gnt_i) begin
      grant_log.push_back(m_addr);
      d = (force_q.size() > 0) ? force_q.pop_front() : $urandom;
      exp_q.push_back(d);
      rsp_data_q.push_back(d);
      due = cyc + $urandom_range(lat_max, 1);
      if (rsp_due_q.size() > 0 && due <= rsp_due_q[$]) due = rsp_due_q[$] + 1;
      rsp_due_q.push_back(due);
      m_addr = m_addr + 32'd4;
      m_left_issue--;
      m_outst++;
    end

    if (start_pend) begin
      start_pend  = 0;
      start_i     = 1'b1;
      base_addr_i = start_base;
      num_words_i = CW'(start_num);
      if (!act_now) begin
        m_addr = {start_base[31:2], 2'b00};
        m_left_issue = start_num;
        m_left_pop = start_num;
        m_sum = '0;
        if (start_num == 0) m_done_next = 1;
        else m_active = 1;
      end
    end else if (act_now && $urandom_range(99) < 3) begin
      start_i = 1'b1;          // must be ignored while busy
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_xfer(input logic [31:0] base, input int num);
    start_pend = 1;
    start_base = base;
    start_num  = num;
    step();
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((m_active || m_done_next) && k < limit) begin
      step();
      k++;
    end
    check("xfer_timeout", {31'b0, (k < limit)}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; num_words_i = '0;
    tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_rdata_i = '0; ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    check("rst_req", {31'b0, tcdm_req_o}, 32'd0);
    check("rst_add", tcdm_add_o, 32'd0);
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_csum", checksum_o, 32'd0);

    // Basic 4-word read with immediate grant and response.
    gnt_pct = 100; rdy_pct = 100; lat_max = 1;
    grant_log.delete(); done_cnt = 0;
    start_xfer(32'h1A00_0000, 4);
    wait_idle(100);
    check("basic_ngrant", grant_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("basic_addr", grant_log[i], 32'h1A00_0000 + 32'(4 * i));
    check("basic_done_cnt", done_cnt, 32'd1);
    repeat (3) step();

    // Zero-length transfer.
    grant_log.delete(); done_cnt = 0;
    start_xfer(32'h0000_1000, 0);
    step();
    check("zero_done_cnt", done_cnt, 32'd1);
    check("zero_ngrant", grant_log.size(), 32'd0);

    // Sink stalled: at most FIFO_DEPTH requests may be granted.
    grant_log.delete(); done_cnt = 0; rdy_pct = 0;
    start_xfer(32'h3000_0040, 8);
    repeat (20) step();
    check("stall_ngrant", grant_log.size(), 32'd4);
    check("stall_req", {31'b0, tcdm_req_o}, 32'd0);
    rdy_pct = 100;
    wait_idle(200);
    check("stall_ngrant_end", grant_log.size(), 32'd8);
    check("stall_done_cnt", done_cnt, 32'd1);

    // Grant withheld for 5 cycles: address and request must hold.
    grant_log.delete(); done_cnt = 0; gnt_pct = 0;
    start_xfer(32'h2000_0003, 3);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_req", {31'b0, tcdm_req_o}, 32'd1);
      check("hold_add", tcdm_add_o, 32'h2000_0000);
    end
    gnt_pct = 100;
    wait_idle(100);
    check("hold_ngrant", grant_log.size(), 32'd3);
    for (int i = 0; i < 3 && i < grant_log.size(); i++)
      check("hold_addr", grant_log[i], 32'h2000_0000 + 32'(4 * i));

    // Reset after two grants, late responses must vanish.
    grant_log.delete(); done_cnt = 0; rdy_pct = 0; lat_max = 4;
    start_xfer(32'h4000_0000, 6);
    for (int k = 0; k < 50 && grant_log.size() < 2; k++) step();
    rst_pend = 1;
    step();
    step();
    check("abort_req", {31'b0, tcdm_req_o}, 32'd0);
    check("abort_add", tcdm_add_o, 32'd0);
    check("abort_valid", {31'b0, valid_o}, 32'd0);
    check("abort_busy", {31'b0, busy_o}, 32'd0);
    check("abort_csum", checksum_o, 32'd0);
    for (int k = 0; k < 30 && rsp_due_q.size() > 0; k++) step();
    step();
    check("abort_late_valid", {31'b0, valid_o}, 32'd0);
    check("abort_no_done", done_cnt, 32'd0);
    rdy_pct = 100;
    start_xfer(32'h5000_0000, 2);
    wait_idle(100);
    check("abort_restart_done", done_cnt, 32'd1);

    // Checksum wrap: 0xFFFFFFFF + 2.
    force_q.delete();
    force_q.push_back(32'hFFFF_FFFF);
    force_q.push_back(32'h0000_0002);
    gnt_pct = 100; lat_max = 1;
    start_xfer(32'h6000_0000, 2);
    wait_idle(100);
`ifdef TCDM_READER_CHECKSUM_EN
    check("csum_wrap", checksum_o, 32'h0000_0001);
`else
    check("csum_off", checksum_o, 32'h0000_0000);
`endif

    // Randomized transfers.
    for (int t = 0; t < 20; t++) begin
      gnt_pct = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 20);
      lat_max = $urandom_range(4, 1);
      done_cnt = 0;
      start_xfer($urandom, $urandom_range(12, 0));
      wait_idle(2000);
      check("rand_done_cnt", done_cnt, 32'd1);
      repeat ($urandom_range(3, 0)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
